// File: rtl/seven_seg_pkg.sv
// Shared digit codes, scan states and the seven-segment glyph table
// for the multiplexed 8-digit display scanner.
package seven_seg_pkg;

  localparam logic [5:0] CODE_BLANK = 6'h10;
  localparam logic [5:0] CODE_MINUS = 6'h11;
  localparam logic [5:0] CODE_X     = 6'h12;
  localparam logic [5:0] CODE_Y     = 6'h13;
  localparam logic [5:0] CODE_Z     = 6'h14;

  localparam logic [6:0] SEG_OFF    = 7'h7F;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Active-low glyphs, bit 0 = CA ... bit 6 = CG.
  function automatic logic [6:0] seg7(input logic [5:0] code);
    logic [6:0] s;
    case (code)
      6'h00:      s = 7'h40;
      6'h01:      s = 7'h79;
      6'h02:      s = 7'h24;
      6'h03:      s = 7'h30;
      6'h04:      s = 7'h19;
      6'h05:      s = 7'h12;
      6'h06:      s = 7'h02;
      6'h07:      s = 7'h78;
      6'h08:      s = 7'h00;
      6'h09:      s = 7'h10;
      6'h0A:      s = 7'h08;
      6'h0B:      s = 7'h03;
      6'h0C:      s = 7'h46;
      6'h0D:      s = 7'h21;
      6'h0E:      s = 7'h06;
      6'h0F:      s = 7'h0E;
      CODE_MINUS: s = 7'h3F;
      CODE_X:     s = 7'h09;
      CODE_Y:     s = 7'h11;
      CODE_Z:     s = 7'h24;
      default:    s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_seg7_decode.sv
// Combinational 6-bit digit code to active-low segment decoder.
// One instance serves whichever digit the scanner is about to drive.
module seg7_decode
  import seven_seg_pkg::*;
(
  input  logic [5:0] code_i,
  output logic [6:0] seg_o
);

  // Glyph lookup shared with the package table.
  always_comb begin
    seg_o = seg7(code_i);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit seven-segment scanner with guard gaps
// and frame-aligned double-buffered display updates.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_CLKS = 100000,
  parameter int GUARD_CLKS   = 100,
  parameter int NUM_DIGITS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] value_i,
  input  logic        load_i,
  input  logic [7:0]  dp_i,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_done_o,
  output logic        pending_o
);

  localparam int MAXC = (REFRESH_CLKS > GUARD_CLKS) ?
                        REFRESH_CLKS : GUARD_CLKS;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [2:0] K_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [47:0] ALL_BLANK = {8{CODE_BLANK}};

  scan_state_e state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_q, frame_d;
  logic          pend_q, pend_d;
  logic [47:0]   shadow_q, shadow_d;
  logic [7:0]    sdp_q, sdp_d;
  logic [47:0]   disp_q, disp_d;
  logic [7:0]    ddp_q, ddp_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    dig_code;
  logic [6:0]    seg_dec;
  logic          guard_last;
  logic          drive_last;

  assign guard_last = (GUARD_CLKS <= 1) ||
                      (cnt_q == CW'(GUARD_CLKS - 1));
  assign drive_last = (cnt_q == CW'(REFRESH_CLKS - 1));

  // Slot sequencing: guard gap, then drive, advancing the digit.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q + CW'(1);
    unique case (state_q)
      GUARD: begin
        if (guard_last) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (drive_last) begin
          cnt_d   = '0;
          k_d     = (k_q == K_LAST) ? 3'd0 : k_q + 3'd1;
          state_d = (GUARD_CLKS == 0) ? DRIVE : GUARD;
        end
      end
      default: begin
        state_d = GUARD;
      end
    endcase
  end

  // Shadow capture and frame-boundary commit; a load wins over commit.
  always_comb begin
    frame_d  = (state_d == DRIVE) && (k_d == K_LAST) &&
               (cnt_d == CW'(REFRESH_CLKS - 1));
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    disp_d   = disp_q;
    ddp_d    = ddp_q;
    pend_d   = pend_q;
    if (frame_q && pend_q) begin
      disp_d = shadow_q;
      ddp_d  = sdp_q;
      pend_d = 1'b0;
    end
    if (load_i) begin
      shadow_d = value_i;
      sdp_d    = dp_i;
      pend_d   = 1'b1;
    end
  end

  assign dig_code = disp_d[6*k_d +: 6];

  seg7_decode u_dec (
    .code_i (dig_code),
    .seg_o  (seg_dec)
  );

  // Output image for the coming cycle, blanked during guard.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == DRIVE) begin
      an_d  = ~(8'd1 << k_d);
      seg_d = seg_dec;
      dp_d  = ~ddp_d[k_d];
    end
  end

  // State, buffers and registered pad outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GUARD;
      k_q      <= '0;
      cnt_q    <= '0;
      frame_q  <= 1'b0;
      pend_q   <= 1'b0;
      shadow_q <= ALL_BLANK;
      sdp_q    <= '0;
      disp_q   <= ALL_BLANK;
      ddp_q    <= '0;
      an_q     <= 8'hFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      disp_q   <= disp_d;
      ddp_q    <= ddp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign AN           = an_q;
  assign SEG          = seg_q;
  assign DP           = dp_q;
  assign frame_done_o = frame_q;
  assign pending_o    = pend_q;

endmodule
